multiplier: RTL and testbench

MULTIPLIER -- requirements
Module: multiplier

---
 rtl/multiplier_pkg.sv | 25 ++
 rtl/multiplier_if.sv | 25 ++
 rtl/multiplier.sv | 71 +++++++
 tb/tb_multiplier.sv | 133 +++++++++++++
 4 files changed

// File: rtl/multiplier_pkg.sv
// Shared CPU package: multiply width and latency, plus decoding of the start
// strobes into a single operation code.
package multiplier_pkg;

    localparam int MULT_WIDTH   = 32;
    // Pipeline stall logic combines this with the divider latency.
    localparam int MULT_LATENCY = MULT_WIDTH;

    typedef enum logic [1:0] {
        MUL_NONE     = 2'd0,
        MUL_SIGNED   = 2'd1,
        MUL_UNSIGNED = 2'd2
    } mult_op_e;

    // The signed strobe wins when both strobes are high in the same cycle.
    function automatic mult_op_e decode_op(input logic op_mult, input logic op_multu);
        if (op_mult) begin
            return MUL_SIGNED;
        end else if (op_multu) begin
            return MUL_UNSIGNED;
        end
        return MUL_NONE;
    endfunction

endpackage

// File: rtl/multiplier_if.sv
// Bundle of start strobes, operands and results between the pipeline and the
// iterative multiplier.
interface multiplier_if
    import multiplier_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
);
    logic             OP_mult;
    logic             OP_multu;
    logic [WIDTH-1:0] Multiplicand;
    logic [WIDTH-1:0] Multiplier;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;
    logic             Stall;

    modport master (
        output OP_mult, OP_multu, Multiplicand, Multiplier,
        input  Hi, Lo, Stall
    );

    modport slave (
        input  OP_mult, OP_multu, Multiplicand, Multiplier,
        output Hi, Lo, Stall
    );
endinterface

// File: rtl/multiplier.sv
// Iterative shift-and-add multiplier, one multiplier bit per cycle.
// Signed operands are reduced to magnitudes at start; the sign is applied to
// the finished product by continuous logic.
module multiplier
    import multiplier_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input logic         clock,
    input logic         reset,
    multiplier_if.slave bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic             active;
    logic             neg;
    logic [CNT_W-1:0] count;
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplr;

    mult_op_e           op;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] raw;
    logic [2*WIDTH-1:0] result;

    assign op  = decode_op(bus.OP_mult, bus.OP_multu);
    assign sum = acc + (mplr[0] ? {1'b0, mcand} : '0);

    // Start captures operands (restarting any running operation); otherwise
    // one add-and-shift step per cycle until the counter runs out.
    always_ff @(posedge clock) begin
        if (reset) begin
            active <= 1'b0;
            neg    <= 1'b0;
            count  <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplr   <= '0;
        end else if (op == MUL_SIGNED) begin
            active <= 1'b1;
            neg    <= bus.Multiplicand[WIDTH-1] ^ bus.Multiplier[WIDTH-1];
            count  <= CNT_W'(WIDTH - 1);
            acc    <= '0;
            mcand  <= bus.Multiplicand[WIDTH-1] ? -bus.Multiplicand : bus.Multiplicand;
            mplr   <= bus.Multiplier[WIDTH-1] ? -bus.Multiplier : bus.Multiplier;
        end else if (op == MUL_UNSIGNED) begin
            active <= 1'b1;
            neg    <= 1'b0;
            count  <= CNT_W'(WIDTH - 1);
            acc    <= '0;
            mcand  <= bus.Multiplicand;
            mplr   <= bus.Multiplier;
        end else if (active) begin
            {acc, mplr} <= {sum, mplr} >> 1;
            count       <= count - 1'b1;
            if (count == '0) begin
                active <= 1'b0;
            end
        end
    end

    // The top accumulator bit is always zero after the final shift.
    assign raw    = {acc[WIDTH-1:0], mplr};
    assign result = neg ? -raw : raw;

    assign bus.Hi    = result[2*WIDTH-1:WIDTH];
    assign bus.Lo    = result[WIDTH-1:0];
    assign bus.Stall = active;

endmodule

// File: tb/tb_multiplier.sv
// Directed bench for the iterative multiplier: latency, signed/unsigned
// products, corner operands, hold, abort, reset and strobe priority.
module tb_multiplier;
    import multiplier_pkg::*;

    localparam int W = 32;

    logic clock;
    logic reset;
    int   tests_run;
    int   tests_failed;
    int   stall_cycles;

    multiplier_if #(.WIDTH(W)) bus ();

    multiplier #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Pulses the chosen strobes for one edge; returns 1 ns after that edge.
    task automatic applyStimulus(input logic do_mult, input logic do_multu,
                                 input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clock);
        bus.OP_mult      = do_mult;
        bus.OP_multu     = do_multu;
        bus.Multiplicand = a;
        bus.Multiplier   = b;
        @(posedge clock);
        #1;
        bus.OP_mult      = 1'b0;
        bus.OP_multu     = 1'b0;
        bus.Multiplicand = $urandom;
        bus.Multiplier   = $urandom;
    endtask

    // Counts cycles with Stall high, bounded so a stuck DUT cannot hang.
    task automatic wait_done(output int cycles);
        cycles = 0;
        while (bus.Stall === 1'b1 && cycles < 200) begin
            cycles++;
            @(posedge clock);
            #1;
        end
    endtask

    task automatic run_op(input string tag, input logic do_mult, input logic do_multu,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [63:0] expected);
        applyStimulus(do_mult, do_multu, a, b);
        wait_done(stall_cycles);
        checkOutput({tag, "_latency"}, 64'(stall_cycles), 64'(MULT_LATENCY));
        checkOutput({tag, "_product"}, {bus.Hi, bus.Lo}, expected);
    endtask

    initial begin
        tests_run        = 0;
        tests_failed     = 0;
        reset            = 1'b1;
        bus.OP_mult      = 1'b0;
        bus.OP_multu     = 1'b0;
        bus.Multiplicand = '0;
        bus.Multiplier   = '0;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("reset_stall", 64'(bus.Stall), 64'd0);
        checkOutput("reset_hilo", {bus.Hi, bus.Lo}, 64'd0);
        @(negedge clock);
        reset = 1'b0;

        run_op("mult_7x6", 1'b1, 1'b0, 32'd7, 32'd6, 64'h00000000_0000002A);
        run_op("multu_ffxff", 1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
        run_op("mult_m1xm1", 1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001);
        run_op("mult_m1x5", 1'b1, 1'b0, 32'hFFFFFFFF, 32'h00000005, 64'hFFFFFFFF_FFFFFFFB);
        run_op("mult_minxmin", 1'b1, 1'b0, 32'h80000000, 32'h80000000, 64'h40000000_00000000);

        repeat (5) @(posedge clock);
        #1;
        checkOutput("hold_stall", 64'(bus.Stall), 64'd0);
        checkOutput("hold_product", {bus.Hi, bus.Lo}, 64'h40000000_00000000);

        run_op("mult_3xm4", 1'b1, 1'b0, 32'd3, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFF4);
        run_op("mult_neg_zero", 1'b1, 1'b0, 32'hFFFFFFFF, 32'd0, 64'd0);

        // Abort: restart ten cycles into a running multiply.
        applyStimulus(1'b0, 1'b1, 32'd3, 32'd4);
        repeat (10) @(posedge clock);
        #1;
        checkOutput("abort_busy", 64'(bus.Stall), 64'd1);
        run_op("abort_restart", 1'b0, 1'b1, 32'h00010000, 32'h00010000, 64'h00000001_00000000);

        // Reset fifteen cycles into a multiply.
        applyStimulus(1'b1, 1'b0, 32'd123, 32'd456);
        repeat (14) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("midreset_stall", 64'(bus.Stall), 64'd0);
        checkOutput("midreset_hilo", {bus.Hi, bus.Lo}, 64'd0);
        @(negedge clock);
        reset = 1'b0;
        stall_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1;
            if (bus.Stall !== 1'b0) stall_cycles++;
        end
        checkOutput("midreset_no_completion", 64'(stall_cycles), 64'd0);
        checkOutput("midreset_hilo_after", {bus.Hi, bus.Lo}, 64'd0);

        run_op("priority_both", 1'b1, 1'b1, 32'hFFFFFFFE, 32'h00000003, 64'hFFFFFFFF_FFFFFFFA);
        run_op("multu_big", 1'b0, 1'b1, 32'h80000000, 32'h00000003, 64'h00000001_80000000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
